// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction-memory request/response bundle for the fetch stage
interface fetch_stage_if;
  logic        ihit;
  logic [31:0] imemload;
  logic        imemREN;
  logic [31:0] imemaddr;

  // fetch stage side: issues the request, consumes the returned word
  modport master (
    input  ihit,
    input  imemload,
    output imemREN,
    output imemaddr
  );

  // memory side: answers the request
  modport slave (
    output ihit,
    output imemload,
    input  imemREN,
    input  imemaddr
  );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC register, instruction fetch and control-flow redirect
module fetch_stage #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000,
  parameter int          WORD_W  = 32
) (
  input  logic                CLK,
  input  logic                RST,
  fetch_stage_if.master       imem,
  input  logic                stall,
  input  logic                beq_out_3,
  input  logic                bne_out_3,
  input  logic                zero_out_3,
  input  logic                j_out_3,
  input  logic                jal_out_3,
  input  logic                JR_out_3,
  input  logic [WORD_W-1:0]   pc_imm_out_3,
  input  logic [WORD_W-1:0]   pc_4_out_3,
  input  logic [25:0]         jumpAddr_out_3,
  input  logic [WORD_W-1:0]   rdat1_out_3,
  input  logic                halt_or_out_4,
  output logic [WORD_W-1:0]   instr_in_1,
  output logic [WORD_W-1:0]   pc_4_in_1,
  output logic                if_wen,
  output logic                flush
);

  typedef enum logic [1:0] {
    FETCH      = 2'd0,
    REDIR_PEND = 2'd1,
    HALTED     = 2'd2
  } state_t;

  state_t              state, next_state;
  logic [WORD_W-1:0]   pc, pc_next;
  logic [WORD_W-1:0]   pend_tgt, pend_next;
  logic                take_br;
  logic                redir;
  logic [WORD_W-1:0]   redir_tgt;
  logic                ren_c, wen_c, flush_c;
  logic                unused_pc4_lo;

  // only the region bits of the resolving PC+4 feed the jump target
  assign unused_pc4_lo = ^pc_4_out_3[WORD_W-5:0];

  // redirect decode: JR beats j/jal, which beats a taken branch
  always_comb begin
    take_br   = (beq_out_3 & zero_out_3) | (bne_out_3 & ~zero_out_3);
    redir     = JR_out_3 | j_out_3 | jal_out_3 | take_br;
    redir_tgt = pc_imm_out_3;
    if (JR_out_3) begin
      redir_tgt = rdat1_out_3;
    end else if (j_out_3 || jal_out_3) begin
      redir_tgt = {pc_4_out_3[WORD_W-1:WORD_W-4], jumpAddr_out_3, 2'b00};
    end
  end

  // next-state, next-PC and handshake outputs
  always_comb begin
    next_state = state;
    pc_next    = pc;
    pend_next  = pend_tgt;
    ren_c      = 1'b0;
    wen_c      = 1'b0;
    flush_c    = 1'b0;
    unique case (state)
      FETCH: begin
        ren_c = 1'b1;
        if (redir) begin
          flush_c = 1'b1;
          if (imem.ihit) begin
            pc_next = redir_tgt;
          end else begin
            // keep the outstanding request stable; remember where to go
            pend_next  = redir_tgt;
            next_state = REDIR_PEND;
          end
        end else if (imem.ihit && !stall) begin
          pc_next = pc + WORD_W'(4);
          wen_c   = 1'b1;
        end
      end
      REDIR_PEND: begin
        ren_c = 1'b1;
        if (redir) begin
          flush_c = 1'b1;
          if (imem.ihit) begin
            pc_next    = redir_tgt;
            next_state = FETCH;
          end else begin
            pend_next = redir_tgt;
          end
        end else if (imem.ihit) begin
          // the returning word belongs to the wrong path and is dropped
          pc_next    = pend_tgt;
          next_state = FETCH;
        end
      end
      HALTED: begin
        ren_c = 1'b0;
      end
      default: begin
        next_state = FETCH;
      end
    endcase
    if (halt_or_out_4) begin
      next_state = HALTED;
      pc_next    = pc;
      pend_next  = pend_tgt;
      wen_c      = 1'b0;
      flush_c    = 1'b0;
    end
    if (RST) begin
      ren_c   = 1'b0;
      wen_c   = 1'b0;
      flush_c = 1'b0;
    end
  end

  // state, PC and pending-target registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= FETCH;
      pc       <= PC_INIT;
      pend_tgt <= '0;
    end else begin
      state    <= next_state;
      pc       <= pc_next;
      pend_tgt <= pend_next;
    end
  end

  assign imem.imemREN  = ren_c;
  assign imem.imemaddr = pc;
  assign if_wen        = wen_c;
  assign flush         = flush_c;
  assign pc_4_in_1     = pc + WORD_W'(4);
  assign instr_in_1    = imem.imemload;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage against a behavioural model
module tb_fetch_stage;
  localparam logic [31:0] PC_INIT = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        RST;
  logic        stall;
  logic        beq_out_3, bne_out_3, zero_out_3;
  logic        j_out_3, jal_out_3, JR_out_3;
  logic [31:0] pc_imm_out_3, pc_4_out_3, rdat1_out_3;
  logic [25:0] jumpAddr_out_3;
  logic        halt_or_out_4;
  logic [31:0] instr_in_1, pc_4_in_1;
  logic        if_wen, flush;

  fetch_stage_if imem();

  fetch_stage #(.PC_INIT(PC_INIT), .WORD_W(32)) dut (
    .CLK(CLK), .RST(RST), .imem(imem), .stall(stall),
    .beq_out_3(beq_out_3), .bne_out_3(bne_out_3), .zero_out_3(zero_out_3),
    .j_out_3(j_out_3), .jal_out_3(jal_out_3), .JR_out_3(JR_out_3),
    .pc_imm_out_3(pc_imm_out_3), .pc_4_out_3(pc_4_out_3),
    .jumpAddr_out_3(jumpAddr_out_3), .rdat1_out_3(rdat1_out_3),
    .halt_or_out_4(halt_or_out_4), .instr_in_1(instr_in_1),
    .pc_4_in_1(pc_4_in_1), .if_wen(if_wen), .flush(flush)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] addr;
    logic        ren;
    logic        wen;
    logic        fl;
    logic [31:0] pc4;
    logic [31:0] instr;
    bit          pin_en;
    logic [31:0] pin;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // behavioural model: where the PC is, whether a redirect is waiting, halted or not
  logic [31:0] m_pc;
  logic [31:0] m_ptgt;
  bit          m_pend;
  bit          m_halt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic clr();
    beq_out_3 = 0; bne_out_3 = 0; zero_out_3 = 0;
    j_out_3 = 0; jal_out_3 = 0; JR_out_3 = 0;
    pc_imm_out_3 = 0; pc_4_out_3 = 0; jumpAddr_out_3 = 0; rdat1_out_3 = 0;
  endtask

  // predict this cycle's outputs, queue them, advance the model across the edge
  task automatic step(input bit pin_en, input logic [31:0] pin);
    exp_t        e;
    bit          go;
    logic [31:0] tg;
    go = 0;
    tg = 0;
    if (JR_out_3) begin
      go = 1; tg = rdat1_out_3;
    end else if (j_out_3 || jal_out_3) begin
      go = 1; tg = {pc_4_out_3[31:28], jumpAddr_out_3, 2'b00};
    end else if ((beq_out_3 && zero_out_3) || (bne_out_3 && !zero_out_3)) begin
      go = 1; tg = pc_imm_out_3;
    end
    if (RST) begin
      m_pc = PC_INIT; m_pend = 0; m_halt = 0; m_ptgt = 0;
      e.addr = PC_INIT; e.ren = 0; e.wen = 0; e.fl = 0;
    end else begin
      e.addr = m_pc;
      e.ren  = !m_halt;
      e.fl   = !m_halt && !halt_or_out_4 && go;
      e.wen  = !m_halt && !halt_or_out_4 && !m_pend && !go && imem.ihit && !stall;
      if (m_halt || halt_or_out_4) begin
        m_halt = 1;
      end else if (go) begin
        if (imem.ihit) begin
          m_pc = tg; m_pend = 0;
        end else begin
          m_ptgt = tg; m_pend = 1;
        end
      end else if (m_pend) begin
        if (imem.ihit) begin
          m_pc = m_ptgt; m_pend = 0;
        end
      end else if (imem.ihit && !stall) begin
        m_pc = m_pc + 32'd4;
      end
    end
    e.pc4    = e.addr + 32'd4;
    e.instr  = imem.imemload;
    e.pin_en = pin_en;
    e.pin    = pin;
    exp_q.push_back(e);
    @(negedge CLK);
  endtask

  task automatic rand_step(input bit pin_en, input logic [31:0] pin);
    imem.ihit     = ($urandom_range(0, 3) != 0);
    stall         = ($urandom_range(0, 3) == 0);
    imem.imemload = $urandom;
    clr();
    if ($urandom_range(0, 5) == 0) begin
      beq_out_3 = 1'($urandom); bne_out_3 = 1'($urandom); zero_out_3 = 1'($urandom);
      j_out_3 = ($urandom_range(0, 5) == 0); jal_out_3 = ($urandom_range(0, 5) == 0);
      JR_out_3 = ($urandom_range(0, 5) == 0);
      pc_imm_out_3 = $urandom & 32'hFFFF_FFFC; pc_4_out_3 = $urandom;
      jumpAddr_out_3 = 26'($urandom); rdat1_out_3 = $urandom & 32'hFFFF_FFFC;
    end
    step(pin_en, pin);
  endtask

  // monitor: every cycle the outputs are valid; compare against the oldest prediction
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("imemaddr", imem.imemaddr, e.addr);
        chk("imemREN", {31'b0, imem.imemREN}, {31'b0, e.ren});
        chk("if_wen", {31'b0, if_wen}, {31'b0, e.wen});
        chk("flush", {31'b0, flush}, {31'b0, e.fl});
        chk("pc_4_in_1", pc_4_in_1, e.pc4);
        chk("instr_in_1", instr_in_1, e.instr);
        if (e.pin_en) chk("imemaddr_directed", imem.imemaddr, e.pin);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1; stall = 0; halt_or_out_4 = 0;
    imem.ihit = 0; imem.imemload = 32'h1234_5678;
    clr();
    m_pc = PC_INIT; m_ptgt = 0; m_pend = 0; m_halt = 0;
    @(negedge CLK);
    step(1, PC_INIT);
    // sequential fetch
    RST = 0; imem.ihit = 1;
    step(1, 32'h0);
    step(1, 32'h4);
    // stall then memory wait at pc=8
    stall = 1;
    step(1, 32'h8); step(1, 32'h8);
    stall = 0; imem.ihit = 0;
    step(1, 32'h8); step(1, 32'h8); step(1, 32'h8);
    imem.ihit = 1;
    step(1, 32'h8);
    // taken beq
    beq_out_3 = 1; zero_out_3 = 1; pc_imm_out_3 = 32'h40;
    step(1, 32'hC);
    clr();
    step(1, 32'h40);
    // not-taken beq
    beq_out_3 = 1; zero_out_3 = 0; pc_imm_out_3 = 32'h40;
    step(1, 32'h44);
    clr();
    step(1, 32'h48);
    // JR beats j
    JR_out_3 = 1; rdat1_out_3 = 32'h100; j_out_3 = 1; jumpAddr_out_3 = 26'h3FF_FFFF;
    step(1, 32'h4C);
    clr();
    j_out_3 = 1; pc_4_out_3 = 32'h1000_0004; jumpAddr_out_3 = 26'h10;
    step(1, 32'h100);
    clr();
    step(1, 32'h1000_0040);
    // bne taken during a miss
    imem.ihit = 0; bne_out_3 = 1; zero_out_3 = 0; pc_imm_out_3 = 32'h80;
    step(1, 32'h1000_0044);
    clr();
    step(1, 32'h1000_0044);
    imem.ihit = 1;
    step(1, 32'h1000_0044);
    step(1, 32'h80);
    // wrap at the top of the address space
    JR_out_3 = 1; rdat1_out_3 = 32'hFFFF_FFFC;
    step(1, 32'h84);
    clr();
    step(1, 32'hFFFF_FFFC);
    step(1, 32'h0);
    // halt then stay parked
    halt_or_out_4 = 1;
    step(1, 32'h4);
    halt_or_out_4 = 0;
    repeat (12) rand_step(1, 32'h4);
    // reset mid-cycle, then resume
    #3;
    RST = 1;
    #1;
    chk("async_reset_addr", imem.imemaddr, PC_INIT);
    @(negedge CLK);
    clr(); stall = 0;
    step(1, PC_INIT);
    RST = 0; imem.ihit = 1;
    step(1, 32'h0);
    step(1, 32'h4);
    // randomized traffic
    repeat (400) rand_step(0, 32'h0);
    clr(); imem.ihit = 0; stall = 0;
    #5;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
